rvr32_lsu: RTL and testbench

RVR32_LSU -- requirements
Module: rvr32_lsu

---
 rtl/rvr32_lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_rvr32_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvr32_lsu.sv
// rvr32_lsu -- RV32I load/store unit with a single outstanding access.
//
// Accepts one load or store from the pipeline, checks funct3 legality and
// alignment, drives one word-wide memory request (lane-replicated store
// data, byte strobes), extracts and extends load data, and returns a
// registered response. A BUSY cycle counter aborts the access with a bus
// timeout error after BUS_TIMEOUT cycles without mem_ready.
//
// Parameters:
//   BUS_TIMEOUT    BUSY cycles without mem_ready before a timeout; 0 disables it
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_*          request from the pipeline (valid/ready handshake)
//   resp_*         response to the pipeline (valid/ready handshake)
//   mem_*          memory port: request held until same-cycle mem_ready
module rvr32_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  localparam int unsigned CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

  state_e            state_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              mem_valid_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic              resp_valid_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  err_e              resp_code_q;

  // Request decode, evaluated on the incoming request fields.
  logic        illegal_d;
  logic        misaligned_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  // Extended load data, evaluated on the returning read word.
  logic [31:0] load_data_d;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        timeout_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    illegal_d    = 1'b0;
    misaligned_d = 1'b0;
    wstrb_d      = 4'b0000;
    wdata_d      = 32'h0;
    // Loads: LB/LH/LW/LBU/LHU (0,1,2,4,5). Stores: SB/SH/SW (0,1,2).
    if (req_store) illegal_d = (req_funct3 > 3'd2);
    else           illegal_d = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    // funct3[1:0] encodes the access size for both loads and stores.
    case (req_funct3[1:0])
      2'b01:   misaligned_d = req_addr[0];
      2'b10:   misaligned_d = (req_addr[1:0] != 2'b00);
      default: misaligned_d = 1'b0;
    endcase
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << req_addr[1:0];
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    rd_byte     = 8'h0;
    load_data_d = mem_rdata;
    case (addr_lo_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_data_d = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_data_d = {24'h0, rd_byte};
      3'd1:    load_data_d = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_data_d = {16'h0, rd_half};
      default: load_data_d = mem_rdata;
    endcase
  end

  // Fires on the BUSY cycle whose increment would reach BUS_TIMEOUT.
  assign timeout_hit = (BUS_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == BUS_TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_code_q  <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            store_q     <= req_store;
            funct3_q    <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (illegal_d || misaligned_d) begin
              // Rejected requests never touch the bus.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 32'h0;
              resp_err_q   <= 1'b1;
              resp_code_q  <= illegal_d ? ERR_FUNCT3 : ERR_MISALIGN;
            end else begin
              state_q     <= S_BUSY;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= wstrb_d;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready || timeout_hit) begin
            // mem_ready wins over a timeout in the same cycle.
            state_q      <= S_RESP;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !mem_ready;
            resp_code_q  <= mem_ready ? ERR_NONE : ERR_TIMEOUT;
            resp_data_q  <= (mem_ready && !store_q) ? load_data_d : 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          // req_ready rises only once IDLE is reached, so the next request
          // is accepted no earlier than the cycle after the handshake.
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          mem_valid_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_valid     = mem_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;
  assign resp_err_code = resp_code_q;

endmodule

// File: tb/tb_rvr32_lsu.sv
// tb_rvr32_lsu -- directed self-checking bench for rvr32_lsu.
// u_dut uses the default timeout; u_dut_to uses BUS_TIMEOUT=4 for the
// timeout scenarios. Both share the stimulus; each test starts from reset.
module tb_rvr32_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        d0_req_ready, d0_resp_valid, d0_resp_err, d0_mem_valid;
  logic [31:0] d0_resp_data, d0_mem_addr, d0_mem_wdata;
  logic [1:0]  d0_resp_err_code;
  logic [3:0]  d0_mem_wstrb;

  logic        d1_req_ready, d1_resp_valid, d1_resp_err, d1_mem_valid;
  logic [31:0] d1_resp_data, d1_mem_addr, d1_mem_wdata;
  logic [1:0]  d1_resp_err_code;
  logic [3:0]  d1_mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rvr32_lsu u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(d0_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(d0_resp_valid), .resp_ready(resp_ready), .resp_data(d0_resp_data),
    .resp_err(d0_resp_err), .resp_err_code(d0_resp_err_code),
    .mem_valid(d0_mem_valid), .mem_ready(mem_ready), .mem_addr(d0_mem_addr),
    .mem_wdata(d0_mem_wdata), .mem_wstrb(d0_mem_wstrb), .mem_rdata(mem_rdata)
  );

  rvr32_lsu #(.BUS_TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(d1_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(d1_resp_valid), .resp_ready(resp_ready), .resp_data(d1_resp_data),
    .resp_err(d1_resp_err), .resp_err_code(d1_resp_err_code),
    .mem_valid(d1_mem_valid), .mem_ready(mem_ready), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_wstrb(d1_mem_wstrb), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  // Single access with mem_ready already high: bus in cycle N+1, response in N+2.
  task automatic do_txn(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_data);
    do_reset();
    issue(st, f3, a, wd);
    mem_ready = 1'b1; mem_rdata = rd;
    tick();
    req_valid = 1'b0;
    check({tag, ".mem_valid"}, 32'(d0_mem_valid), 32'd1);
    check({tag, ".mem_addr"}, d0_mem_addr, exp_addr);
    check({tag, ".mem_wstrb"}, 32'(d0_mem_wstrb), 32'(exp_wstrb));
    if (st) check({tag, ".mem_wdata"}, d0_mem_wdata, exp_wdata);
    tick();
    check({tag, ".resp_valid"}, 32'(d0_resp_valid), 32'd1);
    check({tag, ".resp_data"}, d0_resp_data, exp_data);
    check({tag, ".resp_err"}, 32'(d0_resp_err), 32'd0);
    check({tag, ".mem_drop"}, 32'(d0_mem_valid), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".idle_ready"}, 32'(d0_req_ready), 32'd1);
    check({tag, ".idle_resp"}, 32'(d0_resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    int unstable;
    req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_rdata = 32'h0;

    // Reset state.
    do_reset();
    check("rst.req_ready", 32'(d0_req_ready), 32'd1);
    check("rst.resp_valid", 32'(d0_resp_valid), 32'd0);
    check("rst.mem_valid", 32'(d0_mem_valid), 32'd0);
    check("rst.mem_addr", d0_mem_addr, 32'h0);
    check("rst.mem_wdata", d0_mem_wdata, 32'h0);
    check("rst.mem_wstrb", 32'(d0_mem_wstrb), 32'h0);
    check("rst.resp_data", d0_resp_data, 32'h0);
    check("rst.resp_err", 32'(d0_resp_err), 32'd0);
    check("rst.code", 32'(d0_resp_err_code), 32'd0);

    // Directed single accesses.
    do_txn("lb",  1'b0, 3'd0, 32'h0000_1003, 32'h0,         32'h80FF_0000,
           32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    do_txn("lbu", 1'b0, 3'd4, 32'h0000_1002, 32'h0,         32'h80FF_0000,
           32'h0000_1000, 32'h0, 4'b0000, 32'h0000_00FF);
    do_txn("lh",  1'b0, 3'd1, 32'h0000_0010, 32'h0,         32'h1234_F00D,
           32'h0000_0010, 32'h0, 4'b0000, 32'hFFFF_F00D);
    do_txn("lw",  1'b0, 3'd2, 32'h0000_0024, 32'h0,         32'hDEAD_BEEF,
           32'h0000_0024, 32'h0, 4'b0000, 32'hDEAD_BEEF);
    do_txn("sh",  1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555,
           32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0);
    do_txn("sb",  1'b1, 3'd0, 32'h0000_7001, 32'hAABB_CCDD, 32'h5555_5555,
           32'h0000_7000, 32'hDDDD_DDDD, 4'b0010, 32'h0);
    do_txn("sw",  1'b1, 3'd2, 32'h0000_7008, 32'h0123_4567, 32'h5555_5555,
           32'h0000_7008, 32'h0123_4567, 4'b1111, 32'h0);

    // Misaligned LW, then back-to-back illegal funct3 (also misaligned address).
    do_reset();
    issue(1'b0, 3'd2, 32'h0000_3001, 32'h0);
    tick();
    check("mis.mem_valid", 32'(d0_mem_valid), 32'd0);
    check("mis.resp_valid", 32'(d0_resp_valid), 32'd1);
    check("mis.err", 32'(d0_resp_err), 32'd1);
    check("mis.code", 32'(d0_resp_err_code), 32'h1);
    check("mis.data", d0_resp_data, 32'h0);
    issue(1'b0, 3'd3, 32'h0000_3001, 32'h0);
    resp_ready = 1'b1;
    tick();
    check("b2b.no_accept", 32'(d0_resp_valid), 32'd0);
    check("b2b.req_ready", 32'(d0_req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("ill.resp_valid", 32'(d0_resp_valid), 32'd1);
    check("ill.code", 32'(d0_resp_err_code), 32'h2);
    check("ill.mem_valid", 32'(d0_mem_valid), 32'd0);
    issue(1'b1, 3'd4, 32'h0000_3000, 32'h0);
    tick(); tick();
    req_valid = 1'b0;
    check("ill_st.code", 32'(d0_resp_err_code), 32'h2);
    check("ill_st.err", 32'(d0_resp_err), 32'd1);

    // LHU with mem_ready arriving in the sixth BUSY cycle.
    do_reset();
    issue(1'b0, 3'd5, 32'h0000_4002, 32'h0);
    mem_rdata = 32'h8001_0000;
    tick();
    req_valid = 1'b0;
    n = 0; unstable = 0;
    while (d0_mem_valid && n < 20) begin
      n++;
      if (d0_mem_addr !== 32'h0000_4000 || d0_mem_wstrb !== 4'b0000) unstable++;
      if (n == 6) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check("lhu.busy_cycles", 32'(n), 32'd6);
    check("lhu.stable", 32'(unstable), 32'd0);
    check("lhu.resp_valid", 32'(d0_resp_valid), 32'd1);
    check("lhu.resp_data", d0_resp_data, 32'h0000_8001);
    check("lhu.err", 32'(d0_resp_err), 32'd0);

    // Bus timeout with BUS_TIMEOUT=4, response held while resp_ready is low.
    do_reset();
    issue(1'b0, 3'd2, 32'h0000_5000, 32'h0);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (d1_mem_valid && n < 20) begin
      n++;
      tick();
    end
    check("to.busy_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("to.resp_valid", 32'(d1_resp_valid), 32'd1);
      check("to.err", 32'(d1_resp_err), 32'd1);
      check("to.code", 32'(d1_resp_err_code), 32'h3);
      check("to.data", d1_resp_data, 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("to.released", 32'(d1_resp_valid), 32'd0);

    // mem_ready in the cycle the timeout would fire: success wins.
    do_reset();
    issue(1'b0, 3'd2, 32'h0000_5004, 32'h0);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("race.mem_valid", 32'(d1_mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("race.resp_valid", 32'(d1_resp_valid), 32'd1);
    check("race.err", 32'(d1_resp_err), 32'd0);
    check("race.data", d1_resp_data, 32'hCAFE_F00D);

    // Reset pulsed mid-BUSY abandons the access.
    do_reset();
    issue(1'b0, 3'd2, 32'h0000_6000, 32'h0);
    tick();
    req_valid = 1'b0;
    check("rbusy.mem_valid", 32'(d0_mem_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rbusy.mem_drop", 32'(d0_mem_valid), 32'd0);
    check("rbusy.req_ready", 32'(d0_req_ready), 32'd1);
    check("rbusy.resp_valid", 32'(d0_resp_valid), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    check("rbusy.no_resp", 32'(d0_resp_valid), 32'd0);
    check("rbusy.no_mem", 32'(d0_mem_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
